// File: rtl/wja_axi_regbus_pkg.sv
// Shared constants and helpers for the wja_axi_regbus AXI4-Lite register bridge.
// Word addresses are AXI byte addresses shifted right by two (byte addr = word * 4).
package wja_axi_regbus_pkg;

   localparam int AXI_AW = 8;
   localparam int AXI_DW = 32;
   localparam int LB_W   = 16;
   localparam int WA_W   = AXI_AW - 2;

   localparam logic [WA_W-1:0] ADDR_OREG0 = 6'h00;
   localparam logic [WA_W-1:0] ADDR_OREG1 = 6'h01;
   localparam logic [WA_W-1:0] ADDR_OREG2 = 6'h02;
   localparam logic [WA_W-1:0] ADDR_IREG3 = 6'h03;
   localparam logic [WA_W-1:0] ADDR_IREG4 = 6'h04;
   localparam logic [WA_W-1:0] ADDR_IREG5 = 6'h05;
   localparam logic [WA_W-1:0] ADDR_IREG6 = 6'h06;
   localparam logic [WA_W-1:0] ADDR_IREG7 = 6'h07;
   localparam logic [WA_W-1:0] ADDR_BUSWR = 6'h08;
   localparam logic [WA_W-1:0] ADDR_BUSRD = 6'h09;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Local-bus command word layout as written by the PS: {address, write data}.
   typedef struct packed {
      logic [LB_W-1:0] addr;
      logic [LB_W-1:0] data;
   } lb_cmd_t;

   // Merge new write data into an existing word, byte by byte, under the strobe mask.
   function automatic logic [AXI_DW-1:0] apply_wstrb(
      input logic [AXI_DW-1:0]   old_val,
      input logic [AXI_DW-1:0]   new_val,
      input logic [AXI_DW/8-1:0] strb
   );
      logic [AXI_DW-1:0] res;
      res = old_val;
      for (int i = 0; i < AXI_DW/8; i++) begin
         if (strb[i]) begin
            res[i*8 +: 8] = new_val[i*8 +: 8];
         end else begin
            res[i*8 +: 8] = old_val[i*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/wja_axil_slave_if.sv
// AXI4-Lite handshake engine: turns the five AXI channels into a one-cycle
// write-enable (word address, data, strobes) and a one-cycle read-enable
// (word address) with a registered read-data return.
module wja_axil_slave_if
   import wja_axi_regbus_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   // write address / data / response
   input  logic [WA_W-1:0]     i_awaddr,
   input  logic                i_awvalid,
   output logic                o_awready,
   input  logic [AXI_DW-1:0]   i_wdata,
   input  logic [AXI_DW/8-1:0] i_wstrb,
   input  logic                i_wvalid,
   output logic                o_wready,
   output logic                o_bvalid,
   input  logic                i_bready,
   // read address / data
   input  logic [WA_W-1:0]     i_araddr,
   input  logic                i_arvalid,
   output logic                o_arready,
   output logic [AXI_DW-1:0]   o_rdata,
   output logic                o_rvalid,
   input  logic                i_rready,
   // register-file side
   output logic                o_wr_en,
   output logic [WA_W-1:0]     o_wr_addr,
   output logic [AXI_DW-1:0]   o_wr_data,
   output logic [AXI_DW/8-1:0] o_wr_strb,
   output logic                o_rd_en,
   output logic [WA_W-1:0]     o_rd_addr,
   input  logic [AXI_DW-1:0]   i_rd_data
);

   logic              r_awready;
   logic              r_bvalid;
   logic              r_arready;
   logic              r_rvalid;
   logic [AXI_DW-1:0] r_rdata;
   logic              w_wr_hs;
   logic              w_rd_hs;

   // The write handshake completes on the edge where the ready pulse meets both valids.
   assign w_wr_hs = r_awready & i_awvalid & i_wvalid;
   assign w_rd_hs = r_arready & i_arvalid;

   // Single-cycle AW/W ready pulse, only when both are valid and no response is pending.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_awready <= 1'b0;
      end else begin
         r_awready <= i_awvalid & i_wvalid & ~r_bvalid & ~r_awready;
      end
   end

   // Write response: raised by the handshake, held until the master takes it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bvalid <= 1'b0;
      end else if (w_wr_hs) begin
         r_bvalid <= 1'b1;
      end else if (r_bvalid && i_bready) begin
         r_bvalid <= 1'b0;
      end else begin
         r_bvalid <= r_bvalid;
      end
   end

   // Single-cycle AR ready pulse, blocked while read data is still outstanding.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_arready <= 1'b0;
      end else begin
         r_arready <= i_arvalid & ~r_arready & ~r_rvalid;
      end
   end

   // Read data is captured at the address handshake and presented until accepted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 32'h0000_0000;
      end else if (w_rd_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= i_rd_data;
      end else if (r_rvalid && i_rready) begin
         r_rvalid <= 1'b0;
         r_rdata  <= r_rdata;
      end else begin
         r_rvalid <= r_rvalid;
         r_rdata  <= r_rdata;
      end
   end

   assign o_awready = r_awready;
   assign o_wready  = r_awready;
   assign o_bvalid  = r_bvalid;
   assign o_arready = r_arready;
   assign o_rvalid  = r_rvalid;
   assign o_rdata   = r_rdata;

   assign o_wr_en   = w_wr_hs;
   assign o_wr_addr = i_awaddr;
   assign o_wr_data = i_wdata;
   assign o_wr_strb = i_wstrb;
   assign o_rd_en   = w_rd_hs;
   assign o_rd_addr = i_araddr;

endmodule

// File: rtl/wja_axi_regbus.sv
// AXI4-Lite register bank with a 16-bit local-bus bridge.
// Words 0-2 are PS control registers, 3-7 are PL status inputs, word 8 issues a
// local-bus write and word 9 a local-bus read whose result lands in rdcap.
module wja_axi_regbus
   import wja_axi_regbus_pkg::*;
(
   input  logic                s00_axi_aclk,
   input  logic                s00_axi_areset,
   input  logic [AXI_AW-1:0]   s00_axi_awaddr,
   input  logic [2:0]          s00_axi_awprot,
   input  logic                s00_axi_awvalid,
   output logic                s00_axi_awready,
   input  logic [AXI_DW-1:0]   s00_axi_wdata,
   input  logic [AXI_DW/8-1:0] s00_axi_wstrb,
   input  logic                s00_axi_wvalid,
   output logic                s00_axi_wready,
   output logic [1:0]          s00_axi_bresp,
   output logic                s00_axi_bvalid,
   input  logic                s00_axi_bready,
   input  logic [AXI_AW-1:0]   s00_axi_araddr,
   input  logic [2:0]          s00_axi_arprot,
   input  logic                s00_axi_arvalid,
   output logic                s00_axi_arready,
   output logic [AXI_DW-1:0]   s00_axi_rdata,
   output logic [1:0]          s00_axi_rresp,
   output logic                s00_axi_rvalid,
   input  logic                s00_axi_rready,
   output logic [AXI_DW-1:0]   oreg0,
   output logic [AXI_DW-1:0]   oreg1,
   output logic [AXI_DW-1:0]   oreg2,
   input  logic [AXI_DW-1:0]   ireg3,
   input  logic [AXI_DW-1:0]   ireg4,
   input  logic [AXI_DW-1:0]   ireg5,
   input  logic [AXI_DW-1:0]   ireg6,
   input  logic [AXI_DW-1:0]   ireg7,
   output logic [LB_W-1:0]     baddr,
   output logic [LB_W-1:0]     bwrdata,
   output logic                bwr,
   output logic                bstrobe,
   input  logic [LB_W-1:0]     brddata
);

   logic                w_wr_en;
   logic [WA_W-1:0]     w_wr_addr;
   logic [AXI_DW-1:0]   w_wr_data;
   logic [AXI_DW/8-1:0] w_wr_strb;
   logic                w_rd_en;
   logic [WA_W-1:0]     w_rd_addr;
   logic [AXI_DW-1:0]   w_rd_data;
   lb_cmd_t             w_cmd;
   logic                w_unused;

   logic [AXI_DW-1:0]   r_oreg0;
   logic [AXI_DW-1:0]   r_oreg1;
   logic [AXI_DW-1:0]   r_oreg2;
   logic [LB_W-1:0]     r_baddr;
   logic [LB_W-1:0]     r_bwrdata;
   logic                r_bwr;
   logic                r_bstrobe;
   logic [LB_W-1:0]     r_rdcap;

   // Protection bits and byte-offset address bits carry no meaning here.
   assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   wja_axil_slave_if u_if (
      .i_clk     (s00_axi_aclk),
      .i_rst     (s00_axi_areset),
      .i_awaddr  (s00_axi_awaddr[AXI_AW-1:2]),
      .i_awvalid (s00_axi_awvalid),
      .o_awready (s00_axi_awready),
      .i_wdata   (s00_axi_wdata),
      .i_wstrb   (s00_axi_wstrb),
      .i_wvalid  (s00_axi_wvalid),
      .o_wready  (s00_axi_wready),
      .o_bvalid  (s00_axi_bvalid),
      .i_bready  (s00_axi_bready),
      .i_araddr  (s00_axi_araddr[AXI_AW-1:2]),
      .i_arvalid (s00_axi_arvalid),
      .o_arready (s00_axi_arready),
      .o_rdata   (s00_axi_rdata),
      .o_rvalid  (s00_axi_rvalid),
      .i_rready  (s00_axi_rready),
      .o_wr_en   (w_wr_en),
      .o_wr_addr (w_wr_addr),
      .o_wr_data (w_wr_data),
      .o_wr_strb (w_wr_strb),
      .o_rd_en   (w_rd_en),
      .o_rd_addr (w_rd_addr),
      .i_rd_data (w_rd_data)
   );

   assign w_cmd = lb_cmd_t'(w_wr_data);

   // Control registers take byte-masked writes; every other address is ignored here.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_oreg0 <= 32'h0000_0000;
         r_oreg1 <= 32'h0000_0000;
         r_oreg2 <= 32'h0000_0000;
      end else if (w_wr_en) begin
         case (w_wr_addr)
            ADDR_OREG0: r_oreg0 <= apply_wstrb(r_oreg0, w_wr_data, w_wr_strb);
            ADDR_OREG1: r_oreg1 <= apply_wstrb(r_oreg1, w_wr_data, w_wr_strb);
            ADDR_OREG2: r_oreg2 <= apply_wstrb(r_oreg2, w_wr_data, w_wr_strb);
            default: begin
               r_oreg0 <= r_oreg0;
               r_oreg1 <= r_oreg1;
               r_oreg2 <= r_oreg2;
            end
         endcase
      end else begin
         r_oreg0 <= r_oreg0;
         r_oreg1 <= r_oreg1;
         r_oreg2 <= r_oreg2;
      end
   end

   // Local-bus command launch: latch address/data/direction and fire a one-cycle strobe.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_baddr   <= 16'h0000;
         r_bwrdata <= 16'h0000;
         r_bwr     <= 1'b0;
         r_bstrobe <= 1'b0;
      end else if (w_wr_en && (w_wr_addr == ADDR_BUSWR)) begin
         r_baddr   <= w_cmd.addr;
         r_bwrdata <= w_cmd.data;
         r_bwr     <= 1'b1;
         r_bstrobe <= 1'b1;
      end else if (w_wr_en && (w_wr_addr == ADDR_BUSRD)) begin
         r_baddr   <= w_cmd.addr;
         r_bwrdata <= r_bwrdata;
         r_bwr     <= 1'b0;
         r_bstrobe <= 1'b1;
      end else begin
         r_baddr   <= r_baddr;
         r_bwrdata <= r_bwrdata;
         r_bwr     <= r_bwr;
         r_bstrobe <= 1'b0;
      end
   end

   // User logic answers a local-bus read during the strobe cycle; keep that answer.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_rdcap <= 16'h0000;
      end else if (r_bstrobe && !r_bwr) begin
         r_rdcap <= brddata;
      end else begin
         r_rdcap <= r_rdcap;
      end
   end

   // Readback multiplexer; unmapped words return zero.
   always_comb begin
      w_rd_data = 32'h0000_0000;
      if (w_rd_en) begin
         case (w_rd_addr)
            ADDR_OREG0: w_rd_data = r_oreg0;
            ADDR_OREG1: w_rd_data = r_oreg1;
            ADDR_OREG2: w_rd_data = r_oreg2;
            ADDR_IREG3: w_rd_data = ireg3;
            ADDR_IREG4: w_rd_data = ireg4;
            ADDR_IREG5: w_rd_data = ireg5;
            ADDR_IREG6: w_rd_data = ireg6;
            ADDR_IREG7: w_rd_data = ireg7;
            ADDR_BUSWR: w_rd_data = {r_baddr, r_bwrdata};
            ADDR_BUSRD: w_rd_data = {r_baddr, r_rdcap};
            default:    w_rd_data = 32'h0000_0000;
         endcase
      end else begin
         w_rd_data = 32'h0000_0000;
      end
   end

   assign s00_axi_bresp = RESP_OKAY;
   assign s00_axi_rresp = RESP_OKAY;
   assign oreg0   = r_oreg0;
   assign oreg1   = r_oreg1;
   assign oreg2   = r_oreg2;
   assign baddr   = r_baddr;
   assign bwrdata = r_bwrdata;
   assign bwr     = r_bwr;
   assign bstrobe = r_bstrobe;

endmodule

// File: tb/tb_wja_axi_regbus.sv
// Scoreboard bench for wja_axi_regbus: stimulus tasks queue expected read data,
// write responses and local-bus strobes; a negedge monitor pops and compares.
module tb_wja_axi_regbus;

   logic        clk = 1'b0;
   logic        areset;
   logic [7:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [7:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] oreg0, oreg1, oreg2;
   logic [31:0] ireg3, ireg4, ireg5, ireg6, ireg7;
   logic [15:0] baddr, bwrdata, brddata;
   logic        bwr, bstrobe;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] rq[$];
   logic [1:0]  bq[$];
   logic [32:0] sq[$];

   always #5 clk = ~clk;

   // Simple user logic: one local-bus location answers a read.
   assign brddata = (baddr == 16'h0007) ? 16'hA5A5 : 16'h0000;

   wja_axi_regbus dut (
      .s00_axi_aclk    (clk),
      .s00_axi_areset  (areset),
      .s00_axi_awaddr  (awaddr),
      .s00_axi_awprot  (awprot),
      .s00_axi_awvalid (awvalid),
      .s00_axi_awready (awready),
      .s00_axi_wdata   (wdata),
      .s00_axi_wstrb   (wstrb),
      .s00_axi_wvalid  (wvalid),
      .s00_axi_wready  (wready),
      .s00_axi_bresp   (bresp),
      .s00_axi_bvalid  (bvalid),
      .s00_axi_bready  (bready),
      .s00_axi_araddr  (araddr),
      .s00_axi_arprot  (arprot),
      .s00_axi_arvalid (arvalid),
      .s00_axi_arready (arready),
      .s00_axi_rdata   (rdata),
      .s00_axi_rresp   (rresp),
      .s00_axi_rvalid  (rvalid),
      .s00_axi_rready  (rready),
      .oreg0           (oreg0),
      .oreg1           (oreg1),
      .oreg2           (oreg2),
      .ireg3           (ireg3),
      .ireg4           (ireg4),
      .ireg5           (ireg5),
      .ireg6           (ireg6),
      .ireg7           (ireg7),
      .baddr           (baddr),
      .bwrdata         (bwrdata),
      .bwr             (bwr),
      .bstrobe         (bstrobe),
      .brddata         (brddata)
   );

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic bad(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s", name);
   endtask

   // Monitor: every accepted R beat, B beat and strobe cycle is matched to the queues.
   always @(negedge clk) begin
      if (!areset) begin
         if (rvalid && rready) begin
            if (rq.size() == 0) bad("unexpected_rvalid");
            else begin
               chk("rdata", rdata, rq.pop_front());
               chk("rresp", rresp, 2'b00);
            end
         end
         if (bvalid && bready) begin
            if (bq.size() == 0) bad("unexpected_bvalid");
            else chk("bresp", bresp, bq.pop_front());
         end
         if (bstrobe) begin
            if (sq.size() == 0) bad("unexpected_bstrobe");
            else chk("bstrobe_cmd", {bwr, baddr, bwrdata}, sq.pop_front());
         end
      end
   end

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int bdelay, input bit take_resp);
      int t;
      @(posedge clk); #1;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      if (bdelay > 0 || !take_resp) bready = 1'b0;
      for (t = 0; t < 50 && !awready; t++) @(negedge clk);
      if (!awready) begin
         bad("awready_timeout");
         awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
         return;
      end
      chk("wready_with_awready", wready, 1'b1);
      if (take_resp) bq.push_back(2'b00);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      chk("bvalid_rise", bvalid, 1'b1);
      chk("awready_single", awready, 1'b0);
      if (take_resp) begin
         for (int i = 0; i < bdelay; i++) begin
            @(posedge clk); #1;
            chk("bvalid_hold", bvalid, 1'b1);
         end
         bready = 1'b1;
         @(posedge clk); #1;
         chk("bvalid_fall", bvalid, 1'b0);
      end
   endtask

   task automatic axi_read(input logic [7:0] a, input logic [31:0] exp);
      int t;
      @(posedge clk); #1;
      araddr = a; arvalid = 1'b1;
      for (t = 0; t < 50 && !arready; t++) @(negedge clk);
      if (!arready) begin
         bad("arready_timeout");
         arvalid = 1'b0;
         return;
      end
      rq.push_back(exp);
      @(posedge clk); #1;
      arvalid = 1'b0;
      chk("rvalid_rise", rvalid, 1'b1);
      @(posedge clk); #1;
      chk("rvalid_fall", rvalid, 1'b0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      areset = 1'b1; awaddr = 8'h00; awprot = 3'b000; awvalid = 1'b0;
      wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b1;
      araddr = 8'h00; arprot = 3'b000; arvalid = 1'b0; rready = 1'b1;
      ireg3 = 32'h0; ireg4 = 32'h0; ireg5 = 32'h0; ireg6 = 32'h0; ireg7 = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_axi_outs", {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 9'd0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_oregs", {oreg0, oreg1[15:0]}, 48'h0);
      chk("reset_oreg2", oreg2, 32'h0);
      chk("reset_bus", {bwr, bstrobe, baddr, bwrdata}, 34'h0);
      areset = 1'b0;

      // All mapped words, plus two unmapped ones, read zero after reset.
      for (int i = 0; i < 10; i++) axi_read(8'(i * 4), 32'h0);
      axi_read(8'h28, 32'h0);
      axi_read(8'hFC, 32'h0);

      // Byte-masked write with a late bready.
      axi_write(8'h04, 32'hDEADBEEF, 4'b0101, 3, 1'b1);
      chk("oreg1_masked", oreg1, 32'h00AD00EF);
      chk("oreg0_untouched", oreg0, 32'h0);
      chk("oreg2_untouched", oreg2, 32'h0);
      axi_read(8'h04, 32'h00AD00EF);

      axi_write(8'h00, 32'hCAFEF00D, 4'b1111, 0, 1'b1);
      axi_write(8'h00, 32'h12345678, 4'b1000, 0, 1'b1);
      chk("oreg0_merge", oreg0, 32'h12FEF00D);
      axi_read(8'h00, 32'h12FEF00D);

      // Status inputs are read-only.
      ireg3 = 32'h33330003; ireg4 = 32'h44440004; ireg5 = 32'h12345678;
      ireg6 = 32'h66660006; ireg7 = 32'h77770007;
      axi_read(8'h14, 32'h12345678);
      axi_write(8'h14, 32'hFFFFFFFF, 4'b1111, 0, 1'b1);
      axi_read(8'h14, 32'h12345678);
      axi_read(8'h0C, 32'h33330003);
      axi_read(8'h1C, 32'h77770007);
      axi_write(8'h30, 32'hFFFFFFFF, 4'b1111, 0, 1'b1);
      axi_read(8'h30, 32'h0);
      chk("oregs_after_dropped", {oreg1, oreg2[15:0]}, {32'h00AD00EF, 16'h0000});

      // Local-bus write: wstrb is irrelevant for the command word.
      sq.push_back({1'b1, 16'h0042, 16'h0BEE});
      axi_write(8'h20, 32'h00420BEE, 4'b0000, 0, 1'b1);
      chk("buswr_hold", {bwr, bstrobe, baddr, bwrdata}, {1'b1, 1'b0, 16'h0042, 16'h0BEE});
      axi_read(8'h20, 32'h00420BEE);

      // Local-bus read: bwrdata keeps the last write value.
      sq.push_back({1'b0, 16'h0007, 16'h0BEE});
      axi_write(8'h24, 32'h00070000, 4'b1111, 0, 1'b1);
      axi_read(8'h24, 32'h0007A5A5);
      axi_read(8'h20, 32'h00070BEE);

      // Write and read launched together, then reset while the write response is pending.
      fork
         axi_write(8'h08, 32'h11223344, 4'b1111, 0, 1'b0);
         axi_read(8'h04, 32'h00AD00EF);
      join
      chk("oreg2_written", oreg2, 32'h11223344);
      chk("bvalid_pending", bvalid, 1'b1);
      areset = 1'b1;
      @(posedge clk); #1;
      chk("bvalid_reset_drop", bvalid, 1'b0);
      chk("oreg2_reset", oreg2, 32'h0);
      areset = 1'b0;
      bready = 1'b1;
      axi_read(8'h24, 32'h0);
      axi_read(8'h08, 32'h0);

      // Reset during the AW/W ready pulse of a bus command: no update, no strobe.
      @(posedge clk); #1;
      awaddr = 8'h20; wdata = 32'h0055AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      for (t = 0; t < 50 && !awready; t++) @(negedge clk);
      if (!awready) bad("abort_awready_timeout");
      areset = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(posedge clk); #1;
      chk("abort_no_cmd", {bvalid, bstrobe, awready, baddr, bwrdata}, 35'h0);
      areset = 1'b0;
      @(posedge clk); #1;
      chk("abort_no_strobe", {bstrobe, bvalid}, 2'b00);

      repeat (3) @(posedge clk);
      #1;
      chk("rq_drained", rq.size(), 0);
      chk("bq_drained", bq.size(), 0);
      chk("sq_drained", sq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wja_axi_regbus.md
# wja_axi_regbus

AXI4-Lite slave that exposes eight 32-bit registers to the PS and bridges a simple 16-bit local bus into user logic. Three registers are PS-writable outputs, five are PL-driven readback inputs, and two command addresses issue single-cycle local-bus write/read strobes. The block sits between the Zynq GP AXI port and user fabric logic.

## Interface
Parameters: none (address map fixed in package).

- s00_axi_aclk  in  1  sole clock; all logic on rising edge
- s00_axi_areset  in  1  one clock; reset is synchronous and active-high
- s00_axi_awaddr  in  8  write byte address; bits [7:2] select word
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte enables (registers 0–2 only)
- s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake
- s00_axi_bresp  out  2  always 2'b00 (OKAY)
- s00_axi_bvalid / s00_axi_bready  out / in  1  write response handshake
- s00_axi_araddr  in  8  read byte address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  always 2'b00
- s00_axi_rvalid / s00_axi_rready  out / in  1  read data handshake
- oreg0, oreg1, oreg2  out  32 each  PS-writable control registers
- ireg3 … ireg7  in  32 each  status inputs, read-only
- baddr  out  16  local-bus address, held until next command
- bwrdata  out  16  local-bus write data, held
- bwr  out  1  1 = write, 0 = read; held
- bstrobe  out  1  one-cycle transaction pulse
- brddata  in  16  local-bus read data, sampled during the bstrobe cycle

## Operation
- Word map: 0x00–0x08 oreg0–2 (R/W); 0x0C–0x1C ireg3–7 (RO, writes dropped); 0x20 BUSWR; 0x24 BUSRD; all other addresses read 0, writes dropped, still OKAY.
- Register write: each byte i of oreg0–2 is updated only where wstrb[i]=1.
- BUSWR write: baddr←wdata[31:16], bwrdata←wdata[15:0], bwr←1, bstrobe pulses; wstrb ignored.
- BUSRD write: baddr←wdata[31:16], bwr←0, bstrobe pulses; brddata captured at the end of the strobe cycle into rdcap[15:0]. bwrdata is unchanged.
- BUSWR read returns {baddr, bwrdata}. BUSRD read returns {baddr, rdcap}.
- Reset values: every AXI output is 0, including ready/valid, rdata and resp. oreg0–2=0, baddr=bwrdata=rdcap=0, bwr=0, bstrobe=0.

## Timing
- Write channel: AW and W must both be valid. awready and wready are registered and rise together for exactly one cycle, on the cycle after awvalid&wvalid while bvalid=0 and ready=0. The handshake completes at that edge, and the register update takes effect at that same edge.
- bvalid rises on the cycle after the handshake and holds until bready is sampled high. No new write is accepted while bvalid=1.
- bstrobe for a BUS command is high during the cycle after the handshake edge, concurrent with the first bvalid cycle.
- Read channel: arready pulses one cycle after arvalid while rvalid=0. rdata is latched at the handshake edge, and rvalid rises the next cycle and holds until rready.
- A BUSRD readback issued one cycle after the BUSRD command's bvalid returns the new rdcap.
- Read and write channels are independent and may complete on the same edge.
- Reset asserted mid-transaction aborts it: all valid/ready signals drop the next edge, no partial register update is made, and no strobe is issued.

## Structure
- Package wja_axi_regbus_pkg holds: word address constants (ADDR_OREG0…ADDR_BUSRD), RESP_OKAY=2'b00, and widths AXI_AW=8, AXI_DW=32, LB_W=16.
- One natural sub-module, wja_axil_slave_if, implements the handshake logic. It outputs a write-enable, word address, data and strobe on one side, and a read-enable and word address with a returned data port on the other. The top level holds the register file and local-bus logic.

## Test plan
- Reset then read 0x00–0x24 -> all 0, rresp=00.
- Write 0x04 data 0xDEADBEEF wstrb=4'b0101 after reset -> oreg1=0x00AD00EF; readback matches; bvalid held until bready asserted 3 cycles late.
- Drive ireg5=0x12345678, read 0x14 -> 0x12345678. Write 0x14 -> OKAY, value unchanged.
- Write 0x20 data 0x00420BEE -> single bstrobe cycle with bwr=1, baddr=0x0042, bwrdata=0x0BEE; read 0x20 -> 0x00420BEE.
- User logic returns brddata=0xA5A5 when baddr=0x0007. Write 0x24 data 0x00070000 -> bstrobe with bwr=0; read 0x24 -> 0x0007A5A5.
- Issue a write and a read on the same cycle, then assert reset during bvalid -> both complete correctly, and bvalid drops the edge after reset.
